mult_arbiter_ctrl: RTL and testbench

- Two-requester scheduler for one shared sequential shift-add multiplier.
- Arbitrates round-robin between requesters using valid/ready handshakes.
- Sequences the multiply over WIDTH cycles and returns the 2*WIDTH-bit product tagged with the requester id.
- Sits in front of the counter/multiply datapath so several clients can share one unit.

---
 rtl/mult_arbiter_ctrl.sv | 157 +++++++++++++++
 tb/tb_mult_arbiter_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter_ctrl.sv
// Two-requester round-robin front end for one shared shift-add multiplier.
// Accepts one request at a time, computes over WIDTH cycles, holds the tagged product.
module mult_arbiter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               fast_clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               resp_valid,
    output logic               resp_id,
    output logic [2*WIDTH-1:0] resp_product,
    input  logic               resp_ready,
    output logic               busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_last_grant;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_id;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_resp_valid;
    logic                 r_resp_id;
    logic [2*WIDTH-1:0]   r_resp_product;

    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_accept;
    logic                 w_last_step;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_partial;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Ties go to whichever requester was not served last.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset && r_state == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                if (r_last_grant) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                w_grant0 = 1'b1;
            end else if (req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign w_accept    = w_grant0 | w_grant1;
    assign w_last_step = (r_cnt == CW'(WIDTH - 1));
    assign w_a_ext     = {{WIDTH{1'b0}}, r_a};
    assign w_partial   = r_b[r_cnt] ? (w_a_ext << r_cnt) : '0;
    assign w_acc_next  = r_acc + w_partial;

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last_step) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            r_last_grant   <= 1'b1;
            r_a            <= '0;
            r_b            <= '0;
            r_id           <= 1'b0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_id      <= 1'b0;
            r_resp_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_grant1 ? req1_a : req0_a;
                        r_b          <= w_grant1 ? req1_b : req0_b;
                        r_id         <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_acc        <= '0;
                        r_cnt        <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    // The final partial sum goes straight to the response register.
                    if (w_last_step) begin
                        r_resp_valid   <= 1'b1;
                        r_resp_product <= w_acc_next;
                        r_resp_id      <= r_id;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_resp_valid <= 1'b0;
            endcase
        end
    end

    assign req0_ready   = w_grant0;
    assign req1_ready   = w_grant1;
    assign resp_valid   = r_resp_valid;
    assign resp_id      = r_resp_id;
    assign resp_product = r_resp_product;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_arbiter_ctrl.sv
// Bench for mult_arbiter_ctrl: directed steps plus random traffic
// against a round-robin / a*b reference model.
module tb_mult_arbiter_ctrl;

    localparam int W = 4;

    logic           fast_clk = 1'b0;
    logic           reset;
    logic           req0_valid;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic           req0_ready;
    logic           req1_valid;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic           req1_ready;
    logic           resp_valid;
    logic           resp_id;
    logic [2*W-1:0] resp_product;
    logic           resp_ready;
    logic           busy;

    int vectors = 0;
    int miscompares = 0;
    bit m_last = 1'b1;

    always #5 fast_clk = ~fast_clk;

    mult_arbiter_ctrl #(.WIDTH(W)) dut (
        .fast_clk     (fast_clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_ready   (req1_ready),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .resp_ready   (resp_ready),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_last = 1'b1;
    endtask

    // One request/response round. bp = cycles of held-off resp_ready,
    // blip = pulse req1_valid for one cycle during the compute.
    task automatic run_txn(input bit v0, input int a0, input int b0,
                           input bit v1, input int a1, input int b1,
                           input int bp, input bit blip);
        bit g;
        int pa;
        int pb;
        int exp_p;
        req0_valid = v0;
        req0_a     = W'(a0);
        req0_b     = W'(b0);
        req1_valid = v1;
        req1_a     = W'(a1);
        req1_b     = W'(b1);
        resp_ready = 1'b0;
        #1;
        if (!v0 && !v1) begin
            check("idle_rdy0", {31'b0, req0_ready}, 0);
            check("idle_rdy1", {31'b0, req1_ready}, 0);
            return;
        end
        g = (v0 && v1) ? ~m_last : v1 && !v0;
        check("grant_rdy0", {31'b0, req0_ready}, {31'b0, !g});
        check("grant_rdy1", {31'b0, req1_ready}, {31'b0, g});
        pa = g ? a1 : a0;
        pb = g ? b1 : b0;
        exp_p = (pa % 16) * (pb % 16);
        @(posedge fast_clk);
        #1;
        m_last = g;
        if (g) req1_valid = 1'b0;
        else req0_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (blip) req1_valid = (i == 1);
            resp_ready = 1'($urandom);
            #1;
            check("calc_valid", {31'b0, resp_valid}, 0);
            check("calc_busy", {31'b0, busy}, 1);
            check("calc_rdy", {30'b0, req0_ready, req1_ready}, 0);
            @(posedge fast_clk);
            #1;
        end
        if (blip) req1_valid = 1'b0;
        resp_ready = 1'b0;
        check("resp_valid", {31'b0, resp_valid}, 1);
        check("resp_product", {24'b0, resp_product}, exp_p);
        check("resp_id", {31'b0, resp_id}, {31'b0, g});
        for (int i = 0; i < bp; i++) begin
            tick();
            check("hold_valid", {31'b0, resp_valid}, 1);
            check("hold_product", {24'b0, resp_product}, exp_p);
            check("hold_id", {31'b0, resp_id}, {31'b0, g});
            check("hold_rdy", {30'b0, req0_ready, req1_ready}, 0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("post_valid", {31'b0, resp_valid}, 0);
        check("post_busy", {31'b0, busy}, 0);
        check("post_product", {24'b0, resp_product}, exp_p);
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1;
        req0_a     = '0;
        req0_b     = '0;
        req1_valid = 1'b1;
        req1_a     = '0;
        req1_b     = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        check("rst_rdy", {30'b0, req0_ready, req1_ready}, 0);
        check("rst_valid", {31'b0, resp_valid}, 0);
        check("rst_id", {31'b0, resp_id}, 0);
        check("rst_product", {24'b0, resp_product}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b0;
        m_last     = 1'b1;
        tick();

        run_txn(1, 3, 5, 0, 0, 0, 0, 0);

        do_reset();
        run_txn(1, 15, 15, 1, 2, 7, 0, 0);
        run_txn(0, 0, 0, 1, 2, 7, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_txn(1, $urandom_range(15), $urandom_range(15),
                    1, $urandom_range(15), $urandom_range(15), 0, 0);
        end

        run_txn(0, 0, 0, 1, 9, 0, 5, 0);

        req0_valid = 1'b1;
        req0_a     = 4'd7;
        req0_b     = 4'd6;
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rstmid_busy", {31'b0, busy}, 0);
        check("rstmid_valid", {31'b0, resp_valid}, 0);
        reset  = 1'b0;
        m_last = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("rstmid_noresp", {31'b0, resp_valid}, 0);
            check("rstmid_idle", {31'b0, busy}, 0);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_txn(1, a, b, 0, 0, 0, 0, 0);
            end
        end

        run_txn(1, $urandom_range(15), $urandom_range(15), 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("blip_noresp", {31'b0, resp_valid}, 0);
            check("blip_idle", {31'b0, busy}, 0);
        end

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            run_txn(sel[0], $urandom_range(15), $urandom_range(15),
                    sel[1], $urandom_range(15), $urandom_range(15),
                    $urandom_range(3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
